// File: rtl/rob_commit_ctrl.sv
// In-order retire sequencer for the paired (even/odd) ROB completion-status file.
// Optional build macro ROB_COMMIT_WATCHDOG_EN adds a sticky no-retire hang detector.
module rob_commit_ctrl #(
    parameter int ROB_PAIRS = 16,
`ifdef ROB_COMMIT_WATCHDOG_EN
    parameter int WDOG_LIMIT = 1024,
`endif
    localparam int PTR_W = $clog2(ROB_PAIRS),
    localparam int IDX_W = PTR_W + 1
) (
    input  logic             cpu_clk_i,
    input  logic             cpu_rst_i,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    input  logic [1:0]       disp_mask_i,
    output logic             disp_ready_o,
    output logic [IDX_W-1:0] disp_rob_idx_o,
    output logic [IDX_W-1:0] rob0_status_o,
    output logic [IDX_W-1:0] rob1_status_o,
    input  logic             rob0_done_i,
    input  logic             rob0_call_i,
    input  logic             rob0_ret_i,
    input  logic             rob1_done_i,
    input  logic             rob1_call_i,
    input  logic             rob1_ret_i,
    input  logic             commit_stall_i,
    output logic             commit0_o,
    output logic             commit1_o,
    output logic [1:0]       ras_push_o,
    output logic [1:0]       ras_pop_o,
    output logic [1:0]       retired_cnt_o,
    output logic             rob_empty_o,
    output logic             wdog_hang_o
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     hd_reg, hd_next;
    logic [PTR_W-1:0]     tl_reg, tl_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [ROB_PAIRS-1:0] vld0_reg, vld0_next;
    logic [ROB_PAIRS-1:0] vld1_reg, vld1_next;

    logic head_vld0;
    logic head_vld1;
    logic act;
    logic ok0;
    logic accept;
    logic pair_retire;

    assign head_vld0 = vld0_reg[hd_reg];
    assign head_vld1 = vld1_reg[hd_reg];

    // Ready looks only at registered occupancy, so a full ROB never accepts even while retiring.
    assign disp_ready_o   = (cnt_reg != CNT_W'(ROB_PAIRS));
    assign rob_empty_o    = (cnt_reg == '0);
    assign disp_rob_idx_o = {tl_reg, 1'b0};
    assign rob0_status_o  = {hd_reg, 1'b0};
    assign rob1_status_o  = {hd_reg, 1'b1};

    assign act         = !rob_empty_o && !commit_stall_i && !flush_i;
    assign ok0         = !head_vld0 || rob0_done_i;
    assign commit0_o   = act && head_vld0 && rob0_done_i;
    assign commit1_o   = act && head_vld1 && rob1_done_i && ok0;
    assign pair_retire = act && ok0 && (!head_vld1 || commit1_o);
    assign accept      = disp_valid_i && disp_ready_o && (disp_mask_i != 2'b00) && !flush_i;

    assign ras_push_o    = {commit1_o && rob1_call_i, commit0_o && rob0_call_i};
    assign ras_pop_o     = {commit1_o && rob1_ret_i,  commit0_o && rob0_ret_i};
    assign retired_cnt_o = {commit0_o && commit1_o, commit0_o ^ commit1_o};

    always_comb begin
        hd_next  = hd_reg;
        tl_next  = tl_reg;
        cnt_next = cnt_reg;
        if (flush_i) begin
            hd_next  = '0;
            tl_next  = '0;
            cnt_next = '0;
        end else begin
            if (pair_retire) begin
                hd_next = hd_reg + PTR_W'(1);
            end
            if (accept) begin
                tl_next = tl_reg + PTR_W'(1);
            end
            if (accept && !pair_retire) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end else if (!accept && pair_retire) begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
    end

    // An accepting slot is never the retiring head: accept needs non-full, retire needs non-empty,
    // and tl==hd only at those extremes.
    generate
        for (genvar gi = 0; gi < ROB_PAIRS; gi++) begin : g_slot
            logic sel_tl;
            logic sel_hd;
            assign sel_tl = (tl_reg == PTR_W'(gi));
            assign sel_hd = (hd_reg == PTR_W'(gi));
            assign vld0_next[gi] = flush_i                          ? 1'b0 :
                                   (accept && sel_tl)               ? disp_mask_i[0] :
                                   (sel_hd && (pair_retire || commit0_o)) ? 1'b0 :
                                   vld0_reg[gi];
            assign vld1_next[gi] = flush_i                          ? 1'b0 :
                                   (accept && sel_tl)               ? disp_mask_i[1] :
                                   (sel_hd && pair_retire)          ? 1'b0 :
                                   vld1_reg[gi];
        end
    endgenerate

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            hd_reg   <= '0;
            tl_reg   <= '0;
            cnt_reg  <= '0;
            vld0_reg <= '0;
            vld1_reg <= '0;
        end else begin
            hd_reg   <= hd_next;
            tl_reg   <= tl_next;
            cnt_reg  <= cnt_next;
            vld0_reg <= vld0_next;
            vld1_reg <= vld1_next;
        end
    end

`ifdef ROB_COMMIT_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
    logic              wdog_hang_reg, wdog_hang_next;
    logic              wdog_idle;

    assign wdog_idle = !rob_empty_o && (retired_cnt_o == 2'd0);

    always_comb begin
        wdog_cnt_next  = wdog_cnt_reg;
        wdog_hang_next = wdog_hang_reg;
        if (flush_i) begin
            wdog_cnt_next  = '0;
            wdog_hang_next = 1'b0;
        end else if (retired_cnt_o != 2'd0) begin
            wdog_cnt_next = '0;
        end else if (wdog_idle) begin
            // Counter saturates at the limit; the flag stays set until flush.
            if (wdog_cnt_reg != WDOG_W'(WDOG_LIMIT)) begin
                wdog_cnt_next = wdog_cnt_reg + WDOG_W'(1);
            end
            if (wdog_cnt_reg >= WDOG_W'(WDOG_LIMIT - 1)) begin
                wdog_hang_next = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            wdog_cnt_reg  <= '0;
            wdog_hang_reg <= 1'b0;
        end else begin
            wdog_cnt_reg  <= wdog_cnt_next;
            wdog_hang_reg <= wdog_hang_next;
        end
    end

    assign wdog_hang_o = wdog_hang_reg;
`else
    assign wdog_hang_o = 1'b0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl (16 pairs; watchdog limit 4 when enabled).
module tb_rob_commit_ctrl;

    localparam int IDX_W = 5;
`ifdef ROB_COMMIT_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic             cpu_clk_i = 1'b0;
    logic             cpu_rst_i;
    logic             flush_i;
    logic             disp_valid_i;
    logic [1:0]       disp_mask_i;
    logic             disp_ready_o;
    logic [IDX_W-1:0] disp_rob_idx_o;
    logic [IDX_W-1:0] rob0_status_o;
    logic [IDX_W-1:0] rob1_status_o;
    logic             rob0_done_i, rob0_call_i, rob0_ret_i;
    logic             rob1_done_i, rob1_call_i, rob1_ret_i;
    logic             commit_stall_i;
    logic             commit0_o, commit1_o;
    logic [1:0]       ras_push_o, ras_pop_o, retired_cnt_o;
    logic             rob_empty_o;
    logic             wdog_hang_o;

    int errors = 0;
    int checks = 0;

    rob_commit_ctrl #(
        .ROB_PAIRS(16)
`ifdef ROB_COMMIT_WATCHDOG_EN
        , .WDOG_LIMIT(4)
`endif
    ) dut (
        .cpu_clk_i      (cpu_clk_i),
        .cpu_rst_i      (cpu_rst_i),
        .flush_i        (flush_i),
        .disp_valid_i   (disp_valid_i),
        .disp_mask_i    (disp_mask_i),
        .disp_ready_o   (disp_ready_o),
        .disp_rob_idx_o (disp_rob_idx_o),
        .rob0_status_o  (rob0_status_o),
        .rob1_status_o  (rob1_status_o),
        .rob0_done_i    (rob0_done_i),
        .rob0_call_i    (rob0_call_i),
        .rob0_ret_i     (rob0_ret_i),
        .rob1_done_i    (rob1_done_i),
        .rob1_call_i    (rob1_call_i),
        .rob1_ret_i     (rob1_ret_i),
        .commit_stall_i (commit_stall_i),
        .commit0_o      (commit0_o),
        .commit1_o      (commit1_o),
        .ras_push_o     (ras_push_o),
        .ras_pop_o      (ras_pop_o),
        .retired_cnt_o  (retired_cnt_o),
        .rob_empty_o    (rob_empty_o),
        .wdog_hang_o    (wdog_hang_o)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_i);
        #1;
    endtask

    task automatic set_done(input logic d0, input logic d1);
        rob0_done_i = d0;
        rob1_done_i = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cpu_rst_i = 1'b0;
        flush_i = 1'b0; disp_valid_i = 1'b0; disp_mask_i = 2'b00;
        rob0_done_i = 1'b0; rob0_call_i = 1'b0; rob0_ret_i = 1'b0;
        rob1_done_i = 1'b0; rob1_call_i = 1'b0; rob1_ret_i = 1'b0;
        commit_stall_i = 1'b0;
        #1 cpu_rst_i = 1'b1;
        #1;
        chk("rst_ready", disp_ready_o, 1);
        chk("rst_empty", rob_empty_o, 1);
        chk("rst_idx", disp_rob_idx_o, 0);
        chk("rst_status0", rob0_status_o, 0);
        chk("rst_status1", rob1_status_o, 1);
        chk("rst_commit", {commit0_o, commit1_o}, 0);
        chk("rst_retired", retired_cnt_o, 0);
        chk("rst_wdog", wdog_hang_o, 0);
        #10 cpu_rst_i = 1'b0;
        step();

        // Pair dispatch, both done next cycle
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        #1 chk("t1_idx", disp_rob_idx_o, 0);
        step();
        disp_valid_i = 1'b0; set_done(1, 1);
        #1 chk("t1_commit", {commit0_o, commit1_o}, 2'b11);
        chk("t1_retired", retired_cnt_o, 2);
        chk("t1_nonempty", rob_empty_o, 0);
        step();
        set_done(0, 0);
        #1 chk("t1_status0", rob0_status_o, 2);
        chk("t1_status1", rob1_status_o, 3);
        chk("t1_empty", rob_empty_o, 1);
        $display("txn t1 pair retire: hd -> 1");

        // Zero mask allocates nothing
        disp_valid_i = 1'b1; disp_mask_i = 2'b00;
        step();
        disp_valid_i = 1'b0;
        #1 chk("mask0_empty", rob_empty_o, 1);
        chk("mask0_idx", disp_rob_idx_o, 2);
        $display("txn mask0 dispatch ignored");

        // Odd done, even waits three cycles
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        step();
        disp_valid_i = 1'b0; set_done(0, 1);
        repeat (3) begin
            #1 chk("t2_hold", {commit0_o, commit1_o}, 2'b00);
            step();
        end
        set_done(1, 1);
        #1 chk("t2_commit", {commit0_o, commit1_o}, 2'b11);
        chk("t2_retired", retired_cnt_o, 2);
        step();
        set_done(0, 0);
        #1 chk("t2_status0", rob0_status_o, 4);
        $display("txn t2 odd held behind even");

        // Even retires alone, odd later
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        step();
        disp_valid_i = 1'b0; set_done(1, 0);
        #1 chk("t3_commit0", {commit0_o, commit1_o}, 2'b10);
        chk("t3_retired0", retired_cnt_o, 1);
        step();
        set_done(0, 1);
        #1 chk("t3_status_hold", rob0_status_o, 4);
        chk("t3_commit1", {commit0_o, commit1_o}, 2'b01);
        chk("t3_retired1", retired_cnt_o, 1);
        step();
        set_done(0, 0);
        #1 chk("t3_status_adv", rob0_status_o, 6);
        chk("t3_empty", rob_empty_o, 1);
        $display("txn t3 partial retire");

        // RAS push/pop, with and without stall
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        step();
        disp_valid_i = 1'b0; set_done(1, 1);
        rob0_call_i = 1'b1; rob1_ret_i = 1'b1; commit_stall_i = 1'b1;
        #1 chk("t5_stall_push", ras_push_o, 2'b00);
        chk("t5_stall_pop", ras_pop_o, 2'b00);
        chk("t5_stall_commit", {commit0_o, commit1_o}, 2'b00);
        commit_stall_i = 1'b0;
        #1 chk("t5_push", ras_push_o, 2'b01);
        chk("t5_pop", ras_pop_o, 2'b10);
        chk("t5_retired", retired_cnt_o, 2);
        step();
        set_done(0, 0); rob0_call_i = 1'b0; rob1_ret_i = 1'b0;
        $display("txn t5 ras push/pop");

        // Asynchronous reset mid-operation
        disp_valid_i = 1'b1; disp_mask_i = 2'b01;
        step();
        disp_valid_i = 1'b0;
        #1 chk("arst_pre_empty", rob_empty_o, 0);
        #2 cpu_rst_i = 1'b1;
        #1 chk("arst_empty", rob_empty_o, 1);
        chk("arst_idx", disp_rob_idx_o, 0);
        chk("arst_status0", rob0_status_o, 0);
        #1 cpu_rst_i = 1'b0;
        step();
        $display("txn async reset");

        // Fill all 16 pairs
        for (int i = 0; i < 16; i++) begin
            disp_valid_i = 1'b1; disp_mask_i = 2'b11;
            #1 chk("t4_idx", disp_rob_idx_o, i * 2);
            chk("t4_ready", disp_ready_o, 1);
            step();
        end
        #1 chk("t4_full_ready", disp_ready_o, 0);
        chk("t4_full_idx", disp_rob_idx_o, 0);
        chk("t4_wdog", wdog_hang_o, WD);
        step();
        #1 chk("t4_reject_idx", disp_rob_idx_o, 0);
        set_done(1, 1);
        #1 chk("t4_full_retire", retired_cnt_o, 2);
        chk("t4_no_bypass", disp_ready_o, 0);
        step();
        disp_mask_i = 2'b01; set_done(0, 0);
        #1 chk("t4_ready_after", disp_ready_o, 1);
        chk("t4_wrap_idx", disp_rob_idx_o, 0);
        chk("t4_status0", rob0_status_o, 2);
        step();
        disp_valid_i = 1'b0;
        #1 chk("t4_refull", disp_ready_o, 0);
        chk("t4_idx2", disp_rob_idx_o, 2);
        set_done(1, 1);
        step();
        #1 chk("t4_ready15", disp_ready_o, 1);
        chk("t4_status4", rob0_status_o, 4);
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        #1 chk("t4_both_ret", retired_cnt_o, 2);
        step();
        disp_valid_i = 1'b0; set_done(0, 0);
        #1 chk("t4_both_ready", disp_ready_o, 1);
        chk("t4_both_idx", disp_rob_idx_o, 4);
        chk("t4_both_status", rob0_status_o, 6);
        chk("t4_wdog_sticky", wdog_hang_o, WD);
        $display("txn t4 full/wrap/accept+retire");

        // Flush with everything done and a dispatch offered
        flush_i = 1'b1; set_done(1, 1); rob0_call_i = 1'b1; rob1_ret_i = 1'b1;
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        #1 chk("t6_commit", {commit0_o, commit1_o}, 2'b00);
        chk("t6_push", ras_push_o, 0);
        chk("t6_pop", ras_pop_o, 0);
        chk("t6_retired", retired_cnt_o, 0);
        step();
        flush_i = 1'b0; set_done(0, 0); rob0_call_i = 1'b0; rob1_ret_i = 1'b0;
        disp_valid_i = 1'b0;
        #1 chk("t6_empty", rob_empty_o, 1);
        chk("t6_ready", disp_ready_o, 1);
        chk("t6_idx", disp_rob_idx_o, 0);
        chk("t6_status0", rob0_status_o, 0);
        chk("t6_wdog_clr", wdog_hang_o, 0);
        $display("txn t6 flush");

        // Watchdog: four stalled cycles with work pending
        disp_valid_i = 1'b1; disp_mask_i = 2'b11;
        step();
        disp_valid_i = 1'b0; set_done(1, 1); commit_stall_i = 1'b1;
        repeat (3) step();
        #1 chk("wd_before", wdog_hang_o, 0);
        step();
        #1 chk("wd_hang", wdog_hang_o, WD);
        commit_stall_i = 1'b0;
        step();
        set_done(0, 0);
        #1 chk("wd_sticky", wdog_hang_o, WD);
        chk("wd_empty", rob_empty_o, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1 chk("wd_flush_clr", wdog_hang_o, 0);
        $display("txn watchdog");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
